// File: rtl/io_switch_port_if.sv
// ---------------------------------------------------------------------------
// io_switch_port_if
//   CPU-side memory-mapped I/O bus for the switch/key input port.
//
//   io_addr  [1:0]   register select (word offset inside the I/O window)
//   io_rd            read strobe, one cycle
//   io_wr            write strobe, one cycle
//   io_wdata [31:0]  write data
//   io_rdata [31:0]  registered read data (driven by the port)
//
//   master : CPU / bus decoder side
//   slave  : io_switch_port side
// ---------------------------------------------------------------------------
interface io_switch_port_if;
  logic [1:0]  io_addr;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (
    output io_addr,
    output io_rd,
    output io_wr,
    output io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_addr,
    input  io_rd,
    input  io_wr,
    input  io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/io_switch_port.sv
// ---------------------------------------------------------------------------
// io_switch_port
//   Reader of the board switch/key pins for the memory-mapped I/O window.
//   Each pin is synchronized (2 flops), debounced (DEBOUNCE_CYCLES consecutive
//   disagreeing samples before the level is accepted), and edge events are
//   latched into sticky W1C flags that can raise an interrupt.
//
//   Register map (io_addr):
//     0  debounced level        RO
//     1  rise_flags             read non-destructive, write-1-to-clear
//     2  irq_mask               RW (NUM_SW bits)
//     3  fall_flags             only with IO_SWITCH_FALL_EDGE_EN, else reads 0
//
//   Build option: define IO_SWITCH_FALL_EDGE_EN to add falling-edge flags at
//   address 3 and to let them contribute to irq.
//
//   Ports:
//     clock_50M   system clock, rising edge
//     resetn      asynchronous active-low reset
//     sw_in       raw asynchronous switch pins (bit0 = set0)
//     bus         io_switch_port_if.slave (addr/rd/wr/wdata in, rdata out)
//     sw_level    debounced level
//     irq         registered OR of enabled flags
// ---------------------------------------------------------------------------
module io_switch_port #(
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic              clock_50M,
  input  logic              resetn,
  input  logic [NUM_SW-1:0] sw_in,
  io_switch_port_if.slave   bus,
  output logic [NUM_SW-1:0] sw_level,
  output logic              irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_LEVEL = 2'd0;
  localparam logic [1:0] ADDR_RISE  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;
  localparam logic [1:0] ADDR_FALL  = 2'd3;

  logic [NUM_SW-1:0]            s1_q, s1_d;
  logic [NUM_SW-1:0]            s2_q, s2_d;
  logic [NUM_SW-1:0]            stable_q, stable_d;
  logic [NUM_SW-1:0][CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_SW-1:0]            rise_set;
  logic [NUM_SW-1:0]            rise_clr;
  logic [NUM_SW-1:0]            rise_q, rise_d;
  logic [NUM_SW-1:0]            mask_q, mask_d;
  logic [NUM_SW-1:0]            flags_any;

  logic [31:0]                  rdata_q, rdata_d;
  logic                         irq_q, irq_d;

  logic                         wr_rise;
  logic                         wr_mask;
  logic                         unused_wdata;

`ifdef IO_SWITCH_FALL_EDGE_EN
  logic [NUM_SW-1:0]            fall_set;
  logic [NUM_SW-1:0]            fall_clr;
  logic [NUM_SW-1:0]            fall_q, fall_d;
  logic                         wr_fall;
`endif

  // Zero-extend a NUM_SW-wide register onto the 32-bit read bus; bits at or
  // above NUM_SW always read 0.
  function automatic logic [31:0] zext(input logic [NUM_SW-1:0] v);
    logic [31:0] r;
    r             = '0;
    r[NUM_SW-1:0] = v;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Synchronizer + debounce
  // -------------------------------------------------------------------------
  always_comb begin
    s1_d     = sw_in;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    rise_set = '0;
`ifdef IO_SWITCH_FALL_EDGE_EN
    fall_set = '0;
`endif
    for (int i = 0; i < NUM_SW; i++) begin
      // Any sample that agrees with the accepted level drops the run back to 0,
      // so glitches shorter than DEBOUNCE_CYCLES never reach stable.
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
          rise_set[i] = s2_q[i];
`ifdef IO_SWITCH_FALL_EDGE_EN
          fall_set[i] = ~s2_q[i];
`endif
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register file, read port and interrupt
  // -------------------------------------------------------------------------
  always_comb begin
    wr_rise  = bus.io_wr && (bus.io_addr == ADDR_RISE);
    wr_mask  = bus.io_wr && (bus.io_addr == ADDR_MASK);
    rise_clr = wr_rise ? bus.io_wdata[NUM_SW-1:0] : '0;

    // Set is OR-ed in after the clear so a same-edge event is never lost.
    rise_d   = (rise_q & ~rise_clr) | rise_set;
    mask_d   = wr_mask ? bus.io_wdata[NUM_SW-1:0] : mask_q;

`ifdef IO_SWITCH_FALL_EDGE_EN
    wr_fall   = bus.io_wr && (bus.io_addr == ADDR_FALL);
    fall_clr  = wr_fall ? bus.io_wdata[NUM_SW-1:0] : '0;
    fall_d    = (fall_q & ~fall_clr) | fall_set;
    flags_any = rise_d | fall_d;
`else
    flags_any = rise_d;
`endif

    // Built from next-state values so irq tracks the flags without an extra
    // cycle of lag.
    irq_d   = |(flags_any & mask_d);

    // Reads return pre-edge register contents, so a simultaneous write to the
    // same address is seen only by a later read.
    rdata_d = rdata_q;
    if (bus.io_rd) begin
      case (bus.io_addr)
        ADDR_LEVEL: rdata_d = zext(stable_q);
        ADDR_RISE:  rdata_d = zext(rise_q);
        ADDR_MASK:  rdata_d = zext(mask_q);
`ifdef IO_SWITCH_FALL_EDGE_EN
        ADDR_FALL:  rdata_d = zext(fall_q);
`else
        ADDR_FALL:  rdata_d = '0;
`endif
        default:    rdata_d = '0;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  always_ff @(posedge clock_50M or negedge resetn) begin
    if (!resetn) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
      rise_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

`ifdef IO_SWITCH_FALL_EDGE_EN
  always_ff @(posedge clock_50M or negedge resetn) begin
    if (!resetn) begin
      fall_q <= '0;
    end else begin
      fall_q <= fall_d;
    end
  end
`endif

  // Only the low NUM_SW data bits carry meaning; the rest are deliberately
  // dropped.
  assign unused_wdata = ^bus.io_wdata;

  assign sw_level     = stable_q;
  assign irq          = irq_q;
  assign bus.io_rdata = rdata_q;

endmodule

// File: tb/tb_io_switch_port.sv
// ---------------------------------------------------------------------------
// tb_io_switch_port
//   Bench for io_switch_port (NUM_SW=4, DEBOUNCE_CYCLES=4). A reference model
//   states the debounce rule as "the level flips when the last DEBOUNCE_CYCLES
//   synchronized samples all disagree with it" over a sample history. Reads
//   push the model's expected data into a queue; a negedge monitor pops and
//   compares, and also tracks sw_level and irq every cycle.
// ---------------------------------------------------------------------------
module tb_io_switch_port;
  localparam int NSW = 4;
  localparam int DEB = 4;

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b0;
  logic [NSW-1:0] sw_in    = '0;
  logic [NSW-1:0] sw_level;
  logic           irq;

  int checks   = 0;
  int failures = 0;

  io_switch_port_if bus();

  io_switch_port #(
    .NUM_SW         (NSW),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (16)
  ) dut (
    .clock_50M(clk),
    .resetn   (rst_n),
    .sw_in    (sw_in),
    .bus      (bus),
    .sw_level (sw_level),
    .irq      (irq)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] zx(input logic [NSW-1:0] v);
    return {28'd0, v};
  endfunction

  // ---------------- reference model ----------------
  logic [NSW-1:0] hist[$];
  logic [31:0]    exp_q[$];
  logic [NSW-1:0] m_stable = '0;
  logic [NSW-1:0] m_rise   = '0;
  logic [NSW-1:0] m_fall   = '0;
  logic [NSW-1:0] m_mask   = '0;
  logic           m_irq    = 1'b0;
  logic           rd_pend  = 1'b0;
  logic [NSW-1:0] m_next;
  logic [NSW-1:0] m_clr_r;
  logic [31:0]    m_rd;
  int             m_idx;
  int             m_cnt;
  logic           m_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      exp_q.delete();
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_mask   = '0;
      m_irq    = 1'b0;
      rd_pend  = 1'b0;
    end else begin
      // hist[last] is the pin value at this edge; the debouncer at this edge
      // sees the pin two edges back. Missing history is the reset value 0.
      hist.push_back(sw_in);
      if (hist.size() > DEB + 2) void'(hist.pop_front());
      m_next = m_stable;
      for (int b = 0; b < NSW; b++) begin
        m_cnt = 0;
        for (int j = 0; j < DEB; j++) begin
          m_idx = hist.size() - 3 - j;
          m_v   = (m_idx >= 0) ? hist[m_idx][b] : 1'b0;
          if (m_v != m_stable[b]) m_cnt++;
        end
        if (m_cnt == DEB) m_next[b] = ~m_stable[b];
      end

      rd_pend = bus.io_rd;
      if (bus.io_rd) begin
        case (bus.io_addr)
          2'd0:    m_rd = zx(m_stable);
          2'd1:    m_rd = zx(m_rise);
          2'd2:    m_rd = zx(m_mask);
          default: m_rd = zx(m_fall);
        endcase
        exp_q.push_back(m_rd);
      end

      m_clr_r = (bus.io_wr && bus.io_addr == 2'd1) ? bus.io_wdata[NSW-1:0] : '0;
      if (bus.io_wr && bus.io_addr == 2'd2) m_mask = bus.io_wdata[NSW-1:0];
      m_rise = (m_rise & ~m_clr_r) | (m_next & ~m_stable);
`ifdef IO_SWITCH_FALL_EDGE_EN
      m_fall = (m_fall & ~((bus.io_wr && bus.io_addr == 2'd3) ? bus.io_wdata[NSW-1:0] : '0))
               | (~m_next & m_stable);
`endif
      m_stable = m_next;
      m_irq    = |((m_rise | m_fall) & m_mask);
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      chk("sw_level", zx(sw_level), zx(m_stable));
      chk("irq", {31'd0, irq}, {31'd0, m_irq});
      if (rd_pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rdata_underflow actual=%h expected=queued_entry", bus.io_rdata);
        end else begin
          chk("rdata", bus.io_rdata, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    bus.io_addr  = a;
    bus.io_wdata = d;
    bus.io_wr    = 1'b1;
    cyc();
    bus.io_wr    = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    bus.io_addr = a;
    bus.io_rd   = 1'b1;
    cyc();
    bus.io_rd   = 1'b0;
    d           = bus.io_rdata;
  endtask

  initial begin
    logic [31:0] rd;
    bus.io_addr  = '0;
    bus.io_rd    = 1'b0;
    bus.io_wr    = 1'b0;
    bus.io_wdata = '0;

    // Reset state
    repeat (3) cyc();
    chk("reset_level", zx(sw_level), 32'h0);
    chk("reset_rdata", bus.io_rdata, 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'h0);
    #2 rst_n = 1'b1;
    cyc();

    // Level latency: DEB+2 edges
    sw_in = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 5) chk("latency_before", zx(sw_level), 32'h0);
      if (k == 6) chk("latency_exact", zx(sw_level), 32'h1);
    end
    do_read(2'd1, rd);
    chk("rise_bit0", rd, 32'h1);
    chk("level_upper", zx(sw_level) >> 1, 32'h0);

    // Short glitch on bit1
    sw_in = 4'b0011;
    repeat (3) cyc();
    sw_in = 4'b0001;
    repeat (10) cyc();
    chk("glitch_level", zx(sw_level), 32'h1);
    do_read(2'd1, rd);
    chk("glitch_rise", rd, 32'h1);

    // Interrupt on bit2 rise, cleared by W1C
    do_write(2'd1, 32'h1);
    do_write(2'd2, 32'hF);
    chk("irq_idle", {31'd0, irq}, 32'h0);
    sw_in = 4'b0101;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 5) chk("irq_before", {31'd0, irq}, 32'h0);
      if (k == 6) chk("irq_set", {31'd0, irq}, 32'h1);
    end
    do_write(2'd1, 32'h4);
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    do_read(2'd1, rd);
    chk("rise_cleared", rd, 32'h0);

    // Set/clear collision on bit3
    sw_in = 4'b1101;
    repeat (5) cyc();
    do_write(2'd1, 32'h8);
    chk("collide_level", zx(sw_level), 32'hD);
    do_read(2'd1, rd);
    chk("collide_rise", rd, 32'h8);

    // Simultaneous read and write
    do_write(2'd2, 32'hA);
    bus.io_addr  = 2'd2;
    bus.io_wdata = 32'h5;
    bus.io_rd    = 1'b1;
    bus.io_wr    = 1'b1;
    cyc();
    bus.io_rd    = 1'b0;
    bus.io_wr    = 1'b0;
    chk("rw_old_value", bus.io_rdata, 32'hA);
    do_read(2'd2, rd);
    chk("rw_new_value", rd, 32'h5);
    do_read(2'd0, rd);
    chk("read_level", rd, 32'hD);
    do_write(2'd0, 32'hF);
    chk("rdata_hold", bus.io_rdata, 32'hD);
    do_read(2'd0, rd);
    chk("level_ro", rd, 32'hD);
    do_write(2'd2, 32'hFFFF_FFF0);
    do_read(2'd2, rd);
    chk("mask_upper_ignored", rd, 32'h0);

    // Reset mid-debounce
    do_write(2'd1, 32'hF);
    sw_in = 4'b1100;
    repeat (4) cyc();
    #2 rst_n = 1'b0;
    cyc();
    chk("midreset_level", zx(sw_level), 32'h0);
    #2 rst_n = 1'b1;
    do_read(2'd0, rd);
    chk("post_reset_a0", rd, 32'h0);
    do_read(2'd1, rd);
    chk("post_reset_a1", rd, 32'h0);
    do_read(2'd2, rd);
    chk("post_reset_a2", rd, 32'h0);
    do_read(2'd3, rd);
    chk("post_reset_a3", rd, 32'h0);
    chk("fresh_edge4", zx(sw_level), 32'h0);
    cyc();
    chk("fresh_edge5", zx(sw_level), 32'h0);
    cyc();
    chk("fresh_edge6", zx(sw_level), 32'hC);

    // Falling edge on bit0
    sw_in = 4'b1101;
    repeat (8) cyc();
    sw_in = 4'b1100;
    repeat (8) cyc();
    do_read(2'd3, rd);
`ifdef IO_SWITCH_FALL_EDGE_EN
    chk("fall_flag", rd, 32'h1);
`else
    chk("fall_absent", rd, 32'h0);
`endif
    do_write(2'd3, 32'h1);
    do_read(2'd3, rd);
    chk("fall_cleared", rd, 32'h0);

    // Randomized traffic; the monitor checks against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 799) == 0) begin
        bus.io_rd = 1'b0;
        bus.io_wr = 1'b0;
        #2 rst_n = 1'b0;
        cyc();
        #2 rst_n = 1'b1;
      end
      for (int b = 0; b < NSW; b++) begin
        if (((c / 150) % 2) == 0) begin
          if ($urandom_range(0, 2) == 0) sw_in[b] = ~sw_in[b];
        end else begin
          if ($urandom_range(0, 29) == 0) sw_in[b] = ~sw_in[b];
        end
      end
      bus.io_addr  = 2'($urandom_range(0, 3));
      bus.io_wdata = $urandom();
      bus.io_rd    = ($urandom_range(0, 2) == 0);
      bus.io_wr    = ($urandom_range(0, 5) == 0);
      cyc();
    end
    bus.io_rd = 1'b0;
    bus.io_wr = 1'b0;
    repeat (3) cyc();
    chk("scoreboard_drain", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
